nibble_uart_tx: RTL and testbench
=================================

NIBBLE_UART_TX -- requirements
Module: nibble_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clk cycles per serial bit (legal range 2..255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving nibble FIFO entries (fixed power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port sync_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port o_reg, input, 4 bits: the processor output-register nibble to transmit.
REQ-006 The block SHALL have port o_reg_wr, input, 1 bit: the processor's o_reg write enable, register_enables[8]; high for one cycle per write.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port tx_busy, output, 1 bit: high while a frame is in progress.
REQ-009 The block SHALL have port fifo_full and fifo_empty, outputs, 1 bit each: FIFO status, fed back to i_pins by the top level.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.

Function
REQ-011 On a rising edge with o_reg_wr=1 and FIFO not full, the block SHALL push o_reg; fifo_empty SHALL be low after that edge.
REQ-012 On a rising edge with o_reg_wr=1 and FIFO full with no pop on the same edge, the block SHALL drop the write, leave the FIFO unchanged and set overflow.
REQ-013 A push and a pop on the same edge SHALL both take effect, including when the FIFO is full; the count SHALL be unchanged and overflow SHALL NOT be set.
REQ-014 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from an occupancy count (0..FIFO_DEPTH), never from pointer equality alone.
REQ-015 The FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE -> START SHALL occur on an edge where the FIFO is non-empty; the FIFO SHALL pop on that edge and the head byte SHALL be latched into the shift register.
REQ-017 The transmitted byte SHALL be the ASCII hex of the nibble: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase).
REQ-018 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA SHALL send 8 bits LSB first, each held for CLKS_PER_BIT cycles, with a 3-bit index counting 0..7, then go to STOP.
REQ-020 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then go to IDLE unconditionally.
REQ-021 tx SHALL be registered and SHALL change only on state or bit boundaries, never mid-bit.
REQ-022 Latency: a write at edge k into an empty FIFO while in IDLE SHALL drive tx low after edge k+1.
REQ-023 Back-to-back frames SHALL repeat every 10*CLKS_PER_BIT+1 cycles: exactly one IDLE cycle with tx=1.
REQ-024 tx_busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-025 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reload to 0 at each bit boundary.

Reset
REQ-026 While sync_reset=1 at an edge: tx=1, tx_busy=0, state=IDLE, FIFO count=0, pointers=0, fifo_empty=1, fifo_full=0, overflow=0, baud and bit counters=0.
REQ-027 Reset mid-frame SHALL abort the frame; tx SHALL be 1 after the reset edge, and queued nibbles SHALL be discarded.
REQ-028 o_reg_wr SHALL be ignored on any edge where sync_reset=1.
REQ-029 overflow SHALL clear only on reset.

Verification (bench uses CLKS_PER_BIT=4)
REQ-030 Single write o_reg=0x5 at edge k -> tx low after edge k+1; byte 0x35 LSB first (1,0,1,0,1,1,0,0); stop bit; 40-cycle frame; tx_busy low after.
REQ-031 Write 0xA -> byte 0x41 observed on tx; write 0xF -> 0x46.
REQ-032 Five writes 1,2,3,4,5 on consecutive cycles while idle -> first pops immediately, all five frames sent in order ('1'..'5'), 41-cycle spacing, overflow stays 0.
REQ-033 Six writes on consecutive cycles, no pop after the first -> sixth write dropped, overflow=1, fifo_full=1, only five frames sent, overflow remains 1 afterward.
REQ-034 Full FIFO with push and pop on the same edge -> count stays 4, fifo_full stays 1, overflow stays 0, new nibble transmitted last.
REQ-035 sync_reset asserted at bit 3 of DATA with 2 nibbles queued -> tx=1, tx_busy=0, fifo_empty=1 after the reset edge; no further frames.

Source files
------------

// File: rtl/nibble_uart_tx.sv
// nibble_uart_tx: queues processor nibbles in a small FIFO and sends each as an ASCII hex character, 8N1.
module nibble_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic [3:0] o_reg,
    input  logic       o_reg_wr,
    output logic       tx,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          pop, push, drop, bit_end;

    function automatic logic [7:0] to_hex(input logic [3:0] n);
        return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

    assign fifo_empty = count == '0;
    assign fifo_full  = count == (AW+1)'(FIFO_DEPTH);
    assign pop        = state == IDLE && !fifo_empty;
    // a pop on the same edge frees a slot, so a full FIFO still accepts the write
    assign push       = o_reg_wr && (!fifo_full || pop);
    assign drop       = o_reg_wr && fifo_full && !pop;
    assign tx_busy    = state != IDLE;
    assign bit_end    = baud == BAUD_MAX;

    always_comb begin
        state_n   = state;
        baud_n    = bit_end ? '0 : baud + 8'd1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = tx;
        unique case (state)
            IDLE: begin
                baud_n = '0;
                if (pop) begin
                    state_n = START;
                    shreg_n = to_hex(mem[rd_ptr]);
                    tx_n    = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_n   = DATA;
                bit_idx_n = '0;
                tx_n      = shreg[0];
            end
            DATA: if (bit_end) begin
                state_n   = bit_idx == 3'd7 ? STOP : DATA;
                bit_idx_n = bit_idx == 3'd7 ? bit_idx : bit_idx + 3'd1;
                tx_n      = bit_idx == 3'd7 ? 1'b1 : shreg[bit_idx + 3'd1];
            end
            STOP: if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            rd_ptr   <= rd_ptr + AW'(pop);
            wr_ptr   <= wr_ptr + AW'(push);
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= overflow | drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !sync_reset) mem[wr_ptr] <= o_reg;
    end
endmodule

// File: tb/tb_nibble_uart_tx.sv
// tb_nibble_uart_tx: directed vectors and corner sequences for nibble_uart_tx at 4 clocks per bit.
module tb_nibble_uart_tx;
    localparam int C = 4;

    logic       clk = 1'b0, sync_reset = 1'b1, o_reg_wr = 1'b0;
    logic [3:0] o_reg = 4'h0;
    logic       tx, tx_busy, fifo_full, fifo_empty, overflow;

    nibble_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .clk(clk), .sync_reset(sync_reset), .o_reg(o_reg), .o_reg_wr(o_reg_wr),
        .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    typedef struct {
        logic [3:0] nib;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_rx;
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic write_seq(input logic [3:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            o_reg    = first + 4'(i);
            o_reg_wr = 1'b1;
            tick();
        end
        o_reg_wr = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        while (rx_q.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        chk(name, rx_q.size(), n);
    endtask

    task automatic wait_idle(input string name);
        int b = 200;
        while (tx_busy && b > 0) begin
            tick();
            b--;
        end
        chk(name, tx_busy, 0);
    endtask

    // Line monitor: detects a start bit and samples each bit one cycle after its boundary.
    initial begin
        logic [7:0] b;
        int t;
        forever begin
            tick();
            if (tx === 1'b0) begin
                t = cyc;
                tick();
                for (int i = 0; i < 8; i++) begin
                    repeat (C) tick();
                    b[i] = tx;
                end
                repeat (C) tick();
                chk("stop_bit", 32'(tx), 1);
                rx_q.push_back(b);
                rx_t.push_back(t);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'h5, 8'h35};
        vecs[1] = '{4'hA, 8'h41};
        vecs[2] = '{4'hF, 8'h46};
        vecs[3] = '{4'h0, 8'h30};
        vecs[4] = '{4'h9, 8'h39};

        repeat (2) tick();
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_full", 32'(fifo_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        sync_reset = 1'b0;
        repeat (2) tick();

        // latency and frame length of a single write
        clear_rx();
        write_seq(4'h5, 1);
        chk("lat_k_tx", 32'(tx), 1);
        chk("lat_k_empty", 32'(fifo_empty), 0);
        tick();
        chk("lat_k1_tx", 32'(tx), 0);
        chk("lat_k1_busy", 32'(tx_busy), 1);
        chk("lat_k1_empty", 32'(fifo_empty), 1);
        repeat (39) tick();
        chk("frame_end_busy", 32'(tx_busy), 1);
        chk("frame_end_tx", 32'(tx), 1);
        tick();
        chk("after_frame_busy", 32'(tx_busy), 0);
        wait_frames(1, 20, "lat_frame");
        if (rx_q.size() > 0) chk("lat_byte", 32'(rx_q[0]), 32'h35);

        foreach (vecs[i]) begin
            clear_rx();
            write_seq(vecs[i].nib, 1);
            wait_frames(1, 80, "tab_frame");
            if (rx_q.size() > 0) chk("tab_byte", 32'(rx_q[0]), 32'(vecs[i].exp));
            wait_idle("tab_idle");
            tick();
        end

        // five back-to-back writes
        clear_rx();
        write_seq(4'h1, 5);
        wait_frames(5, 300, "five_frames");
        for (int i = 0; i < rx_q.size() && i < 5; i++) chk("five_byte", 32'(rx_q[i]), 32'h31 + 32'(i));
        for (int i = 0; i + 1 < rx_t.size() && i < 4; i++) chk("five_spacing", rx_t[i+1] - rx_t[i], 10 * C + 1);
        chk("five_ovf", 32'(overflow), 0);
        wait_idle("five_idle");
        tick();

        // six writes: the last one overflows
        clear_rx();
        write_seq(4'h1, 6);
        chk("six_ovf", 32'(overflow), 1);
        chk("six_full", 32'(fifo_full), 1);
        wait_frames(5, 300, "six_frames");
        repeat (100) tick();
        chk("six_count", rx_q.size(), 5);
        if (rx_q.size() > 4) chk("six_last", 32'(rx_q[4]), 32'h35);
        chk("six_ovf_sticky", 32'(overflow), 1);
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);
        tick();

        // push and pop on the same edge while full
        clear_rx();
        write_seq(4'h7, 5);
        chk("pp_full_before", 32'(fifo_full), 1);
        wait_idle("pp_idle");
        chk("pp_full_idle", 32'(fifo_full), 1);
        o_reg    = 4'hC;
        o_reg_wr = 1'b1;
        tick();
        o_reg_wr = 1'b0;
        chk("pp_full_after", 32'(fifo_full), 1);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_busy", 32'(tx_busy), 1);
        wait_frames(6, 400, "pp_frames");
        if (rx_q.size() > 5) begin
            chk("pp_b0", 32'(rx_q[0]), 32'h37);
            chk("pp_b3", 32'(rx_q[3]), 32'h41);
            chk("pp_b4", 32'(rx_q[4]), 32'h42);
            chk("pp_b5", 32'(rx_q[5]), 32'h43);
        end
        chk("pp_ovf_end", 32'(overflow), 0);
        wait_idle("pp_end_idle");
        tick();

        // reset during data bit 3 with two nibbles queued
        clear_rx();
        write_seq(4'h1, 3);
        repeat (15) tick();
        chk("mid_bit3", 32'(tx), 0);
        sync_reset = 1'b1;
        o_reg      = 4'h6;
        o_reg_wr   = 1'b1;
        tick();
        sync_reset = 1'b0;
        o_reg_wr   = 1'b0;
        chk("abort_tx", 32'(tx), 1);
        chk("abort_busy", 32'(tx_busy), 0);
        chk("abort_empty", 32'(fifo_empty), 1);
        chk("abort_full", 32'(fifo_full), 0);
        repeat (30) tick();
        clear_rx();
        repeat (150) tick();
        chk("abort_no_frames", rx_q.size(), 0);
        chk("abort_tx_idle", 32'(tx), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
